// File: rtl/vpu_pkg.sv
// vpu_pkg: shared VPU widths, decoded-instruction struct and destination-port FSM states
package vpu_pkg;
  localparam int DWIDTH_PER_EXEC = 256;
  localparam int EXEC_CNT = 2;
  localparam int EXEC_CNT_LG2 = 1;
  localparam int SRAM_DATA_WIDTH = EXEC_CNT * DWIDTH_PER_EXEC;
  localparam int SRAM_ADDR_WIDTH = 8;
  typedef struct packed {
    logic                       wvalid;
    logic [SRAM_ADDR_WIDTH-1:0] waddr;
  } vpu_instr_decoded_t;
  typedef enum logic [1:0] {
    DST_IDLE,
    DST_COLLECT,
    DST_WRITE,
    DST_DONE
  } vpu_dst_state_e;
endpackage

// File: rtl/vpu_dst_port.sv
// vpu_dst_port: packs EXEC_CNT lane result beats into one SRAM word and writes it (clk/rst_n, start/done, result valid/ready, sram wren/waddr/wdata/wack, sticky overflow)
module vpu_dst_port
  import vpu_pkg::*;
#(
  parameter int DWIDTH_PER_EXEC = vpu_pkg::DWIDTH_PER_EXEC,
  parameter int EXEC_CNT        = vpu_pkg::EXEC_CNT,
  parameter int SRAM_ADDR_WIDTH = vpu_pkg::SRAM_ADDR_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  vpu_pkg::vpu_instr_decoded_t           instr_decoded_i,
  input  logic                                  start_i,
  output logic                                  done_o,
  input  logic                                  result_valid_i,
  input  logic [DWIDTH_PER_EXEC-1:0]            result_i,
  output logic                                  result_ready_o,
  output logic                                  sram_wren_o,
  output logic [SRAM_ADDR_WIDTH-1:0]            sram_waddr_o,
  output logic [EXEC_CNT*DWIDTH_PER_EXEC-1:0]   sram_wdata_o,
  input  logic                                  sram_wack_i,
  output logic                                  overflow_o
);
  localparam int SDW = EXEC_CNT * DWIDTH_PER_EXEC;
  localparam int CW  = EXEC_CNT > 1 ? $clog2(EXEC_CNT) : 1;
  vpu_dst_state_e             state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [SDW-1:0]             buf_q, buf_d;
  logic [SRAM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                       ovf_q, ovf_d;
  logic                       last_beat;
  assign last_beat = cnt_q == CW'(EXEC_CNT - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    waddr_d = waddr_q;
    ovf_d   = ovf_q | (result_valid_i && state_q != DST_COLLECT);
    case (state_q)
      DST_IDLE, DST_DONE: begin
        if (start_i) begin
          state_d = instr_decoded_i.wvalid ? DST_COLLECT : DST_DONE;
          if (instr_decoded_i.wvalid) begin
            waddr_d = SRAM_ADDR_WIDTH'(instr_decoded_i.waddr);
            cnt_d   = '0;
          end
        end
      end
      DST_COLLECT: begin
        if (result_valid_i) begin
          buf_d[cnt_q*DWIDTH_PER_EXEC +: DWIDTH_PER_EXEC] = result_i;
          cnt_d   = last_beat ? '0 : cnt_q + 1'b1;
          state_d = last_beat ? DST_WRITE : DST_COLLECT;
        end
      end
      DST_WRITE: state_d = sram_wack_i ? DST_DONE : DST_WRITE;
      default:   state_d = DST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      waddr_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      waddr_q <= waddr_d;
      ovf_q   <= ovf_d;
    end
  end
  // done is masked by start so the controller never sees a stale done from the previous instruction
  assign done_o         = state_q == DST_DONE && !start_i;
  assign result_ready_o = state_q == DST_COLLECT;
  assign sram_wren_o    = state_q == DST_WRITE;
  assign sram_waddr_o   = waddr_q;
  assign sram_wdata_o   = buf_q;
  assign overflow_o     = ovf_q;
endmodule

// File: tb/tb_vpu_dst_port.sv
// tb_vpu_dst_port: directed table-driven checks of beat packing, SRAM handshake, overflow and reset
module tb_vpu_dst_port;
  import vpu_pkg::*;
  localparam int DW = 256;
  localparam int SW = 512;
  logic               clk = 0;
  logic               rst_n = 0;
  vpu_instr_decoded_t instr = '0;
  logic               start = 0;
  logic               done;
  logic               rvalid = 0;
  logic [DW-1:0]      rdata = '0;
  logic               rready;
  logic               wren;
  logic [7:0]         waddr;
  logic [SW-1:0]      wdata;
  logic               wack = 0;
  logic               ovf;
  int                 n_tests = 0;
  int                 n_fail = 0;
  int                 writes = 0;
  typedef struct {
    logic          wvalid;
    logic [7:0]    addr;
    logic [DW-1:0] b0;
    logic [DW-1:0] b1;
    int            gap;
    int            dly;
    logic [SW-1:0] exp_data;
  } vec_t;
  vec_t vecs[4];
  vpu_dst_port dut (
    .clk(clk), .rst_n(rst_n), .instr_decoded_i(instr), .start_i(start), .done_o(done),
    .result_valid_i(rvalid), .result_i(rdata), .result_ready_o(rready),
    .sram_wren_o(wren), .sram_waddr_o(waddr), .sram_wdata_o(wdata),
    .sram_wack_i(wack), .overflow_o(ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rst_n && wren && wack) writes <= writes + 1;
  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_instr(input vec_t v);
    int w0;
    logic [DW-1:0] beats[2];
    beats[0] = v.b0;
    beats[1] = v.b1;
    w0 = writes;
    @(negedge clk);
    start = 1;
    instr.wvalid = v.wvalid;
    instr.waddr = v.addr;
    #1 chk("done_masked_by_start", SW'(done), 0);
    @(negedge clk);
    start = 0;
    instr = '0;
    if (!v.wvalid) begin
      #1;
      chk("nowrite_done", SW'(done), 1);
      chk("nowrite_ready", SW'(rready), 0);
      chk("nowrite_wren", SW'(wren), 0);
      repeat (2) @(negedge clk);
      chk("nowrite_wren_late", SW'(wren), 0);
      chk("nowrite_ready_late", SW'(rready), 0);
      chk("nowrite_count", SW'(writes - w0), 0);
      return;
    end
    chk("collect_ready", SW'(rready), 1);
    chk("collect_done", SW'(done), 0);
    for (int b = 0; b < 2; b++) begin
      if (b > 0) repeat (v.gap) begin
        rvalid = 0;
        @(negedge clk);
        chk("gap_ready", SW'(rready), 1);
        chk("gap_wren", SW'(wren), 0);
      end
      rvalid = 1;
      rdata = beats[b];
      @(negedge clk);
    end
    rvalid = 0;
    rdata = '0;
    for (int i = 0; i < v.dly; i++) begin
      chk("wait_wren", SW'(wren), 1);
      chk("wait_addr", SW'(waddr), SW'(v.addr));
      chk("wait_data", wdata, v.exp_data);
      chk("wait_done", SW'(done), 0);
      @(negedge clk);
    end
    wack = 1;
    #1;
    chk("write_wren", SW'(wren), 1);
    chk("write_ready", SW'(rready), 0);
    chk("write_addr", SW'(waddr), SW'(v.addr));
    chk("write_data", wdata, v.exp_data);
    @(negedge clk);
    wack = 0;
    #1;
    chk("after_wack_wren", SW'(wren), 0);
    chk("after_wack_done", SW'(done), 1);
    chk("write_count", SW'(writes - w0), 1);
  endtask
  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 8'h12, {64{4'hA}}, {64{4'hB}}, 0, 0, {{64{4'hB}}, {64{4'hA}}}};
    vecs[1] = '{1'b1, 8'h34, {64{4'hA}}, {64{4'hB}}, 2, 3, {{64{4'hB}}, {64{4'hA}}}};
    vecs[2] = '{1'b0, 8'h55, '0, '0, 0, 0, '0};
    vecs[3] = '{1'b1, 8'h7F, DW'(1), {DW{1'b1}}, 1, 1, {{DW{1'b1}}, DW'(1)}};
    #1;
    chk("rst_done", SW'(done), 0);
    chk("rst_ready", SW'(rready), 0);
    chk("rst_wren", SW'(wren), 0);
    chk("rst_waddr", SW'(waddr), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ovf", SW'(ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) run_instr(vecs[i]);
    chk("no_ovf_yet", SW'(ovf), 0);
    // overflow: beat offered in IDLE and during WRITE
    @(negedge clk);
    rst_n = 0;
    #1 chk("rst2_wdata", wdata, 0);
    @(negedge clk);
    rst_n = 1;
    rvalid = 1;
    rdata = {64{4'hC}};
    @(negedge clk);
    rvalid = 0;
    chk("idle_ovf", SW'(ovf), 1);
    chk("idle_ready", SW'(rready), 0);
    start = 1;
    instr.wvalid = 1;
    instr.waddr = 8'h21;
    @(negedge clk);
    start = 0;
    rvalid = 1;
    rdata = DW'(3);
    @(negedge clk);
    rdata = DW'(4);
    @(negedge clk);
    rdata = {64{4'hE}};
    @(negedge clk);
    rvalid = 0;
    chk("writewait_wren", SW'(wren), 1);
    chk("writewait_data", wdata, {DW'(4), DW'(3)});
    wack = 1;
    @(negedge clk);
    wack = 0;
    chk("ovf_sticky", SW'(ovf), 1);
    chk("ovf_done", SW'(done), 1);
    repeat (3) @(negedge clk);
    chk("ovf_still", SW'(ovf), 1);
    // reset mid-COLLECT abandons the instruction
    start = 1;
    instr.wvalid = 1;
    instr.waddr = 8'h40;
    @(negedge clk);
    start = 0;
    rvalid = 1;
    rdata = {64{4'h9}};
    @(negedge clk);
    rvalid = 0;
    #2 rst_n = 0;
    #1;
    chk("async_rst_ready", SW'(rready), 0);
    chk("async_rst_ovf", SW'(ovf), 0);
    chk("async_rst_wdata", wdata, 0);
    chk("async_rst_waddr", SW'(waddr), 0);
    @(negedge clk);
    rst_n = 1;
    v = '{1'b1, 8'h05, DW'(1), DW'(2), 0, 0, {DW'(2), DW'(1)}};
    begin
      int w0;
      w0 = writes;
      repeat (3) begin
        @(negedge clk);
        chk("post_rst_wren", SW'(wren), 0);
      end
      chk("post_rst_nowrite", SW'(writes - w0), 0);
    end
    run_instr(v);
    v = '{1'b1, 8'h06, DW'(7), DW'(8), 0, 2, {DW'(8), DW'(7)}};
    run_instr(v);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vpu_dst_port.md
VPU_DST_PORT -- requirements
Module: VPU_DST_PORT

Interface
REQ-001 SHALL take parameter DWIDTH_PER_EXEC, default VPU_PKG::DWIDTH_PER_EXEC (256), lane result beat width.
REQ-002 SHALL take parameter EXEC_CNT, default VPU_PKG::EXEC_CNT (2), beats per SRAM word; SRAM_DATA_WIDTH = EXEC_CNT*DWIDTH_PER_EXEC.
REQ-003 SHALL take parameter SRAM_ADDR_WIDTH, default VPU_PKG::SRAM_ADDR_WIDTH (8), write address width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 instr_decoded_i  input  VPU_PKG::vpu_instr_decoded_t  supplies wvalid (1 b) and waddr (SRAM_ADDR_WIDTH).
REQ-007 start_i  input  1  one-cycle pulse from VPU_CONTROLLER starting an instruction.
REQ-008 done_o  output  1  instruction writeback complete.
REQ-009 result_valid_i  input  1  lane beat valid.
REQ-010 result_i  input  DWIDTH_PER_EXEC  lane result beat.
REQ-011 result_ready_o  output  1  block accepts a beat this cycle.
REQ-012 sram_wren_o  output  1  SRAM write request.
REQ-013 sram_waddr_o  output  SRAM_ADDR_WIDTH  write address.
REQ-014 sram_wdata_o  output  SRAM_DATA_WIDTH  write data.
REQ-015 sram_wack_i  input  1  SRAM accepts the request this cycle.
REQ-016 overflow_o  output  1  sticky: beat offered while not ready.

Function
REQ-017 SHALL implement FSM states IDLE, COLLECT, WRITE, DONE.
REQ-018 IDLE + start_i + wvalid=1: latch waddr, clear beat counter, go to COLLECT.
REQ-019 IDLE + start_i + wvalid=0: go directly to DONE; no SRAM write.
REQ-020 result_ready_o SHALL be 1 only in COLLECT.
REQ-021 COLLECT: on result_valid_i, store result_i at bits [cnt*DWIDTH_PER_EXEC +: DWIDTH_PER_EXEC] (beat 0 = LSBs), cnt++.
REQ-022 COLLECT: beat accepted with cnt==EXEC_CNT-1 SHALL move to WRITE next cycle; cnt wraps to 0.
REQ-023 WRITE: sram_wren_o=1 with stable sram_waddr_o/sram_wdata_o until sram_wack_i; request held through any number of wait cycles.
REQ-024 WRITE + sram_wack_i: go to DONE next cycle; sram_wren_o low in that cycle.
REQ-025 done_o SHALL be 1 in DONE and 0 in every other state; combinationally forced 0 while start_i=1.
REQ-026 DONE + start_i: behave as IDLE + start_i (REQ-018/019) in the same cycle; otherwise remain in DONE.
REQ-027 start_i in COLLECT or WRITE SHALL be ignored.
REQ-028 result_valid_i outside COLLECT: beat dropped, overflow_o set; cleared only by reset.
REQ-029 Write latency: sram_wren_o SHALL rise the cycle after the last beat is accepted.
REQ-030 sram_wdata_o SHALL be driven from the registered buffer only, never from result_i directly.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, cnt 0, buffer 0, latched address 0, overflow_o 0.
REQ-032 Output values under reset: done_o 0, result_ready_o 0, sram_wren_o 0, sram_waddr_o 0, sram_wdata_o 0.
REQ-033 Reset mid-COLLECT or mid-WRITE SHALL abandon the instruction; no write issued after release.

Structure
REQ-034 DWIDTH_PER_EXEC, EXEC_CNT, EXEC_CNT_LG2, SRAM_DATA_WIDTH, SRAM_ADDR_WIDTH, vpu_instr_decoded_t and the FSM state enum SHALL live in VPU_PKG.
REQ-035 Single module, no sub-modules; an assembly buffer of EXEC_CNT beats plus counter and FSM.

Verification
REQ-036 start, wvalid=1, waddr=0x12; beats 0xA..A, 0xB..B back-to-back; wack same cycle -> one write, addr 0x12, data {B..B,A..A}, done_o 1 cycle after wack.
REQ-037 Same with 2-cycle idle gap between beats, wack delayed 3 cycles -> wren held 4 cycles, addr/data stable, single write.
REQ-038 start with wvalid=0 -> DONE next cycle, sram_wren_o never 1, result_ready_o never 1.
REQ-039 result_valid_i asserted in IDLE and WRITE -> beat ignored, overflow_o=1 until reset, written data unchanged.
REQ-040 rst_n low after first beat, released, new start waddr=0x05 with beats 1,2 -> exactly one write, addr 0x05, data {2,1}.
REQ-041 Two instructions back-to-back (start in DONE) -> done_o drops with start_i, second write to new address correct.
